ibex_alu_pext_satpack: RTL and testbench

- Result-side counterpart of the P-ext control decoder.
- Takes per-lane extended adder sums produced under the decoded width, sign and subtract controls, and applies wrap, halve or saturate.
- Repacks the lanes into a 32-bit result through a one-deep valid/ready output register.
- Owns the sticky vxsat (OV) CSR bit, which is set when a saturating op's result is handed off.

---
 rtl/ibex_pkg_pext.sv | 16 +
 rtl/ibex_alu_pext_lane_sat.sv | 50 +++++
 rtl/ibex_alu_pext_satpack.sv | 135 +++++++++++++
 tb/tb_ibex_alu_pext_satpack.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ibex_pkg_pext.sv
// Shared types for the packed-SIMD (P-extension) result path.
// Holds the result-mode encoding and the width of the packed lane-sum bus.
package ibex_pkg_pext;

  // How each lane's extended sum is reduced back to its lane width.
  // Encoding 3 is reserved, and consumers must treat it as RES_WRAP.
  typedef enum logic [1:0] {
    RES_WRAP  = 2'd0,
    RES_HALVE = 2'd1,
    RES_SAT   = 2'd2
  } pext_res_mode_e;

  // Width of the packed bus. It holds four 9-bit lanes or two 18-bit lanes.
  localparam int PEXT_SUM_W = 36;

endpackage

// File: rtl/ibex_alu_pext_lane_sat.sv
// Reduces one lane's (LANE_W+1)-bit extended sum to LANE_W bits.
// The mode selects wrap, halve or saturate, and ov_o flags a clamped result.
module ibex_alu_pext_lane_sat
  import ibex_pkg_pext::*;
#(
  parameter int LANE_W = 8
) (
  input  logic [LANE_W:0]   s_i,
  input  logic              signed_i,
  input  logic              sub_i,
  input  pext_res_mode_e    mode_i,
  output logic [LANE_W-1:0] r_o,
  output logic              ov_o
);

  logic [LANE_W-1:0] w_min;
  logic [LANE_W-1:0] w_max;

  assign w_min = {1'b1, {(LANE_W-1){1'b0}}};
  assign w_max = {1'b0, {(LANE_W-1){1'b1}}};

  // Select the lane result. A signed overflow shows up as a disagreement
  // between the two top sum bits. An unsigned carry or borrow shows up in the
  // extra top bit, and the direction decides whether to clamp to ones or zero.
  always_comb begin
    r_o  = s_i[LANE_W-1:0];
    ov_o = 1'b0;
    case (mode_i)
      RES_HALVE: begin
        r_o = s_i[LANE_W:1];
      end
      RES_SAT: begin
        if (signed_i) begin
          if (s_i[LANE_W] != s_i[LANE_W-1]) begin
            ov_o = 1'b1;
            r_o  = s_i[LANE_W] ? w_min : w_max;
          end
        end else if (s_i[LANE_W]) begin
          ov_o = 1'b1;
          r_o  = sub_i ? '0 : '1;
        end
      end
      default: begin
        r_o  = s_i[LANE_W-1:0];
        ov_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/ibex_alu_pext_satpack.sv
// Result side of the P-extension ALU.
// It reduces per-lane sums, repacks them into a 32-bit word and hands the word
// off through a one-deep valid/ready register. It also owns the sticky vxsat bit.
module ibex_alu_pext_satpack
  import ibex_pkg_pext::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [PEXT_SUM_W-1:0] sum_i,
  input  logic                  width32_i,
  input  logic                  width8_i,
  input  logic                  signed_i,
  input  logic [1:0]            sub_i,
  input  logic [1:0]            res_mode_i,
  input  logic                  flush_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [31:0]           result_o,
  output logic [3:0]            lane_ov_o,
  input  logic                  csr_we_i,
  input  logic                  csr_wdata_i,
  output logic                  vxsat_o
);

  pext_res_mode_e w_mode;
  logic [31:0]    w_res8;
  logic [31:0]    w_res16;
  logic [31:0]    w_res32;
  logic [3:0]     w_ov8;
  logic [1:0]     w_ov16;
  logic           w_ov32;
  logic [31:0]    w_resSel;
  logic [3:0]     w_ovSel;
  logic           w_capture;
  logic           w_handoff;
  logic           w_satSet;

  logic           r_valid;
  logic [31:0]    r_result;
  logic [3:0]     r_laneOv;
  logic           r_vxsat;

  assign w_mode = pext_res_mode_e'(res_mode_i);

  // Every width runs in parallel. The width controls only pick which
  // set of lane results reaches the output register.
  for (genvar k = 0; k < 4; k++) begin : g_lane8
    ibex_alu_pext_lane_sat #(.LANE_W(8)) u_lane8 (
      .s_i      (sum_i[9*k +: 9]),
      .signed_i (signed_i),
      .sub_i    (sub_i[0]),
      .mode_i   (w_mode),
      .r_o      (w_res8[8*k +: 8]),
      .ov_o     (w_ov8[k])
    );
  end

  for (genvar k = 0; k < 2; k++) begin : g_lane16
    ibex_alu_pext_lane_sat #(.LANE_W(16)) u_lane16 (
      .s_i      (sum_i[18*k +: 17]),
      .signed_i (signed_i),
      .sub_i    (sub_i[k]),
      .mode_i   (w_mode),
      .r_o      (w_res16[16*k +: 16]),
      .ov_o     (w_ov16[k])
    );
  end

  ibex_alu_pext_lane_sat #(.LANE_W(32)) u_lane32 (
    .s_i      (sum_i[32:0]),
    .signed_i (signed_i),
    .sub_i    (sub_i[0]),
    .mode_i   (w_mode),
    .r_o      (w_res32),
    .ov_o     (w_ov32)
  );

  // Choose the lane set by width. A 32-bit lane takes priority over the
  // 8-bit flag. Each wider lane's overflow is spread across every byte it covers.
  always_comb begin
    w_resSel = w_res16;
    w_ovSel  = {w_ov16[1], w_ov16[1], w_ov16[0], w_ov16[0]};
    if (width32_i) begin
      w_resSel = w_res32;
      w_ovSel  = {4{w_ov32}};
    end else if (width8_i) begin
      w_resSel = w_res8;
      w_ovSel  = w_ov8;
    end
  end

  assign ready_o   = !r_valid || out_ready_i;
  assign w_capture = valid_i && ready_o;
  assign w_handoff = r_valid && out_ready_i;
  assign w_satSet  = w_handoff && !flush_i && (|r_laneOv);

  // Output register. A flush wins over a capture in the same cycle.
  // A capture refills the register on the same cycle that a handoff empties it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_valid  <= 1'b0;
      r_result <= '0;
      r_laneOv <= '0;
    end else if (flush_i) begin
      r_valid  <= 1'b0;
      r_laneOv <= '0;
    end else if (w_capture) begin
      r_valid  <= 1'b1;
      r_result <= w_resSel;
      r_laneOv <= w_ovSel;
    end else if (w_handoff) begin
      r_valid  <= 1'b0;
    end
  end

  // Sticky saturation flag. A saturating handoff overrides a CSR write in the
  // same cycle, so software cannot miss an overflow while it clears the flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_vxsat <= 1'b0;
    end else if (w_satSet) begin
      r_vxsat <= 1'b1;
    end else if (csr_we_i) begin
      r_vxsat <= csr_wdata_i;
    end
  end

  assign out_valid_o = r_valid;
  assign result_o    = r_result;
  assign lane_ov_o   = r_laneOv;
  assign vxsat_o     = r_vxsat;

endmodule

// File: tb/tb_ibex_alu_pext_satpack.sv
// Self-checking bench for the P-extension saturate/pack result stage.
// A behavioural model tracks the expected outputs alongside the design.
module tb_ibex_alu_pext_satpack;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic        ready;
  logic [35:0] sum;
  logic        w32;
  logic        w8;
  logic        sgn;
  logic [1:0]  sub;
  logic [1:0]  mode;
  logic        flush;
  logic        outValid;
  logic        outReady;
  logic [31:0] result;
  logic [3:0]  laneOv;
  logic        csrWe;
  logic        csrWdata;
  logic        vxsat;

  int checks = 0;
  int errors = 0;

  logic        mValid;
  logic [31:0] mResult;
  logic [3:0]  mOv;
  logic        mVx;
  logic [31:0] held;

  always #5 clk = ~clk;

  ibex_alu_pext_satpack dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .valid_i     (valid),
    .ready_o     (ready),
    .sum_i       (sum),
    .width32_i   (w32),
    .width8_i    (w8),
    .signed_i    (sgn),
    .sub_i       (sub),
    .res_mode_i  (mode),
    .flush_i     (flush),
    .out_valid_o (outValid),
    .out_ready_i (outReady),
    .result_o    (result),
    .lane_ov_o   (laneOv),
    .csr_we_i    (csrWe),
    .csr_wdata_i (csrWdata),
    .vxsat_o     (vxsat)
  );

  // Compare one observed value against the bench's expectation.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model. Each lane is read as an integer and clamped to the
  // lane's numeric range, instead of testing individual bits.
  task automatic refCompute(input logic [35:0] s36, input logic iw32, input logic iw8,
                            input logic isgn, input logic [1:0] isub, input logic [1:0] imode,
                            output logic [31:0] res, output logic [3:0] ov);
    int     n;
    int     lanes;
    int     stride;
    longint s;
    longint v;
    longint r;
    longint modN;
    logic   lov;
    logic   subFlag;
    res = '0;
    ov  = '0;
    if (iw32) begin n = 32; lanes = 1; stride = 33; end
    else if (iw8) begin n = 8; lanes = 4; stride = 9; end
    else begin n = 16; lanes = 2; stride = 18; end
    modN = longint'(1) << n;
    for (int k = 0; k < lanes; k++) begin
      s       = (longint'(s36) >> (k * stride)) & ((modN << 1) - 1);
      subFlag = (n == 16) ? isub[k] : isub[0];
      lov     = 1'b0;
      r       = s % modN;
      if (imode == 2'd1) begin
        r = s / 2;
      end else if (imode == 2'd2) begin
        if (isgn) begin
          v = (s >= modN) ? s - 2 * modN : s;
          if (v > modN / 2 - 1) begin r = modN / 2 - 1; lov = 1'b1; end
          else if (v < -(modN / 2)) begin r = modN / 2; lov = 1'b1; end
          else r = (v + modN) % modN;
        end else if (s >= modN) begin
          lov = 1'b1;
          r   = subFlag ? 0 : modN - 1;
        end
      end
      res = res | (32'(r) << (k * n));
      if (lov) ov = ov | (4'((1 << (n / 8)) - 1) << (k * n / 8));
    end
  endtask

  // Run one clock cycle. Check ready_o mid-cycle, advance the model at the
  // clock edge, then check the registered outputs just after the edge.
  task automatic applyStimulus(input string tag);
    logic        mReady;
    logic        satSet;
    logic [31:0] nr;
    logic [3:0]  no;
    @(negedge clk);
    mReady = !mValid || outReady;
    checkOutput({tag, "/ready"}, 64'(ready), 64'(mReady));
    @(posedge clk);
    satSet = mValid && outReady && !flush && (|mOv);
    refCompute(sum, w32, w8, sgn, sub, mode, nr, no);
    mVx = satSet ? 1'b1 : (csrWe ? csrWdata : mVx);
    if (flush) begin
      mValid = 1'b0;
      mOv    = '0;
    end else if (valid && mReady) begin
      mValid  = 1'b1;
      mResult = nr;
      mOv     = no;
    end else if (outReady) begin
      mValid = 1'b0;
    end
    #1;
    checkOutput({tag, "/out_valid"}, 64'(outValid), 64'(mValid));
    if (mValid) checkOutput({tag, "/result"}, 64'(result), 64'(mResult));
    checkOutput({tag, "/lane_ov"}, 64'(laneOv), 64'(mOv));
    checkOutput({tag, "/vxsat"}, 64'(vxsat), 64'(mVx));
  endtask

  task automatic setIdle();
    valid = 0; sum = '0; w32 = 0; w8 = 0; sgn = 0; sub = '0; mode = '0;
    flush = 0; outReady = 1; csrWe = 0; csrWdata = 0;
  endtask

  task automatic setSat8();
    w8 = 1; w32 = 0; sgn = 1; sub = 2'b00; mode = 2'd2;
    sum = {9'h000, 9'h000, 9'h17F, 9'h080};
  endtask

  initial begin
    setIdle();
    rst = 1;
    mValid = 0; mResult = '0; mOv = '0; mVx = 0;
    #12;
    checkOutput("reset/out_valid", 64'(outValid), 64'd0);
    checkOutput("reset/result", 64'(result), 64'd0);
    checkOutput("reset/lane_ov", 64'(laneOv), 64'd0);
    checkOutput("reset/vxsat", 64'(vxsat), 64'd0);
    checkOutput("reset/ready", 64'(ready), 64'd1);
    @(negedge clk);
    rst = 0;
    @(posedge clk); #1;

    // 8-bit signed saturating add, both overflow directions.
    setSat8(); valid = 1;
    applyStimulus("sat8");
    checkOutput("sat8/const_result", 64'(result), 64'h0000_807F);
    checkOutput("sat8/const_ov", 64'(laneOv), 64'b0011);
    valid = 0;
    applyStimulus("sat8_handoff");
    checkOutput("sat8/const_vxsat", 64'(vxsat), 64'd1);

    // 16-bit unsigned saturate, with a borrow in the low lane and a carry in the high lane.
    setIdle(); valid = 1; sgn = 0; sub = 2'b01; mode = 2'd2;
    sum = {18'h10000, 18'h1FFFF};
    applyStimulus("sat16");
    checkOutput("sat16/const_result", 64'(result), 64'hFFFF_0000);
    checkOutput("sat16/const_ov", 64'(laneOv), 64'b1111);
    valid = 0;
    applyStimulus("sat16_handoff");

    // 32-bit signed halve. It must not raise any overflow flag.
    setIdle(); valid = 1; w32 = 1; sgn = 1; mode = 2'd1;
    sum = 36'h1_0000_0002;
    applyStimulus("halve32");
    checkOutput("halve32/const_result", 64'(result), 64'h8000_0001);
    checkOutput("halve32/const_ov", 64'(laneOv), 64'd0);
    valid = 0;
    applyStimulus("halve32_handoff");
    checkOutput("halve32/const_vxsat", 64'(vxsat), 64'd1);

    // Backpressure: the held result must not change, and releasing it accepts new data.
    setIdle(); valid = 1; w8 = 1; outReady = 0;
    sum = {4'h0, $urandom()};
    applyStimulus("bp_fill");
    held = result;
    for (int i = 0; i < 3; i++) begin
      sum = {4'h0, $urandom()};
      applyStimulus("bp_hold");
      checkOutput("bp/const_ready", 64'(ready), 64'd0);
      checkOutput("bp/stable", 64'(result), 64'(held));
    end
    outReady = 1; sum = {4'h0, $urandom()};
    applyStimulus("bp_release");
    checkOutput("bp/const_valid", 64'(outValid), 64'd1);
    valid = 0;
    applyStimulus("bp_drain");

    // A flushed OV result must not set vxsat. A CSR write cannot override a saturating handoff.
    setIdle(); csrWe = 1; csrWdata = 0;
    applyStimulus("clr");
    csrWe = 0; setSat8(); valid = 1; outReady = 0;
    applyStimulus("fl_fill");
    valid = 0;
    applyStimulus("fl_hold");
    flush = 1; outReady = 1;
    applyStimulus("flush");
    checkOutput("flush/const_vxsat", 64'(vxsat), 64'd0);
    flush = 0; csrWe = 1; csrWdata = 0;
    applyStimulus("fl_wr0");
    checkOutput("fl_wr0/const_vxsat", 64'(vxsat), 64'd0);
    csrWe = 0; valid = 1; outReady = 0;
    applyStimulus("race_fill");
    valid = 0; outReady = 1; csrWe = 1; csrWdata = 0;
    applyStimulus("race");
    checkOutput("race/const_vxsat", 64'(vxsat), 64'd1);

    // Randomized traffic across every width, mode, handshake and CSR combination.
    for (int i = 0; i < 120; i++) begin
      valid    = 1'($urandom_range(0, 3) != 0);
      sum      = {4'($urandom()), $urandom()};
      w32      = 1'($urandom_range(0, 2) == 0);
      w8       = 1'($urandom());
      sgn      = 1'($urandom());
      sub      = 2'($urandom());
      mode     = 2'($urandom());
      flush    = 1'($urandom_range(0, 9) == 0);
      outReady = 1'($urandom_range(0, 3) != 0);
      csrWe    = 1'($urandom_range(0, 7) == 0);
      csrWdata = 1'($urandom());
      applyStimulus("rand");
    end

    // Asserting reset in the middle of a cycle must clear the held result and vxsat at once.
    setIdle(); csrWe = 1; csrWdata = 1;
    applyStimulus("rst_setvx");
    csrWe = 0; setSat8(); valid = 1; outReady = 0;
    applyStimulus("rst_fill");
    valid = 0;
    applyStimulus("rst_hold");
    #3;
    rst = 1;
    #1;
    mValid = 0; mOv = '0; mVx = 0; mResult = '0;
    checkOutput("async_rst/out_valid", 64'(outValid), 64'd0);
    checkOutput("async_rst/vxsat", 64'(vxsat), 64'd0);
    checkOutput("async_rst/ready", 64'(ready), 64'd1);
    @(negedge clk);
    rst = 0;
    setIdle();
    applyStimulus("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
